// File: rtl/rr_rec_pkg.sv
// Shared types and packet layout helpers for the record/replay logging path.
// Packet layout, MSB to LSB: {seq, busy[nch], ispkt[nch], data[nch*w]}.
package rr_rec_pkg;

  localparam int SEQ_W_DEF = 16;

  function automatic int rr_pkt_width(input int nch, input int w, input int seq_w = SEQ_W_DEF);
    return seq_w + 2 * nch + nch * w;
  endfunction

  function automatic int rr_data_lsb(input int slot, input int w);
    return slot * w;
  endfunction

  function automatic int rr_ispkt_lsb(input int nch, input int w);
    return nch * w;
  endfunction

  function automatic int rr_busy_lsb(input int nch, input int w);
    return nch * w + nch;
  endfunction

  function automatic int rr_seq_lsb(input int nch, input int w);
    return nch * w + 2 * nch;
  endfunction

endpackage

// File: rtl/rr_sync_fifo.sv
// Single-clock FIFO with the head entry read straight from the storage registers.
// Push at full and pop at empty are excluded by the caller.
module rr_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  always_ff @(posedge i_clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/rr_multichan_recorder.sv
// Inline recorder for NCH valid/ready channels: passes beats through, captures them
// per channel, and merges the FIFO heads into sequence-numbered log packets.
module rr_multichan_recorder
  import rr_rec_pkg::*;
#(
  parameter int NCH   = 3,
  parameter int W     = 64,
  parameter int DEPTH = 32,
  parameter int SEQ_W = SEQ_W_DEF
) (
  input  logic                                 clk,
  input  logic                                 sync_rst_n,
  input  logic                                 rec_en,
  input  logic [NCH*W-1:0]                     src_din,
  input  logic [NCH-1:0]                       src_valid,
  output logic [NCH-1:0]                       src_ready,
  output logic [NCH-1:0]                       dst_valid,
  input  logic [NCH-1:0]                       dst_ready,
  output logic [NCH*W-1:0]                     dst_dout,
  output logic                                 rec_valid,
  input  logic                                 rec_ready,
  output logic [rr_pkt_width(NCH, W, SEQ_W)-1:0] rec_pkt
);

  localparam int PW        = rr_pkt_width(NCH, W, SEQ_W);
  localparam int SEQ_LSB   = rr_seq_lsb(NCH, W);
  localparam int BUSY_LSB  = rr_busy_lsb(NCH, W);
  localparam int ISPKT_LSB = rr_ispkt_lsb(NCH, W);

  logic [NCH-1:0]   w_full, w_empty, w_gate, w_fire, w_push, w_pop, w_stall;
  logic [W-1:0]     w_head [NCH];
  logic [NCH*W-1:0] w_data;
  logic             w_load;
  logic [PW-1:0]    w_pkt_next;

  logic             r_rec_valid;
  logic [PW-1:0]    r_rec_pkt;
  logic [NCH-1:0]   r_busy;
  logic [SEQ_W-1:0] r_seq;

  // A new packet may load whenever something is queued and the output slot is free.
  assign w_load = ~(&w_empty) & (~r_rec_valid | rec_ready);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    // Gating uses pre-pop occupancy, so a full FIFO stalls even in a cycle it is popped.
    assign w_gate[g]    = rec_en & w_full[g];
    assign dst_valid[g] = src_valid[g] & ~w_gate[g];
    assign src_ready[g] = dst_ready[g] & ~w_gate[g];
    assign w_fire[g]    = src_valid[g] & dst_ready[g] & ~w_gate[g];
    assign w_stall[g]   = src_valid[g] & dst_ready[g] & w_gate[g];
    assign w_push[g]    = rec_en & w_fire[g];
    assign w_pop[g]     = w_load & ~w_empty[g];
    assign w_data[g*W +: W] = w_empty[g] ? '0 : w_head[g];

    rr_sync_fifo #(
      .WIDTH (W),
      .DEPTH (DEPTH)
    ) u_fifo (
      .i_clk   (clk),
      .i_rst_n (sync_rst_n),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_din   (src_din[g*W +: W]),
      .o_head  (w_head[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  assign dst_dout = src_din;

  always_comb begin
    w_pkt_next = '0;
    w_pkt_next[SEQ_LSB +: SEQ_W]  = r_seq;
    w_pkt_next[BUSY_LSB +: NCH]   = r_busy | w_stall;
    w_pkt_next[ISPKT_LSB +: NCH]  = ~w_empty;
    w_pkt_next[NCH*W-1:0]         = w_data;
  end

  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_rec_valid <= 1'b0;
      r_rec_pkt   <= '0;
      r_busy      <= '0;
      r_seq       <= '0;
    end else if (w_load) begin
      r_rec_valid <= 1'b1;
      r_rec_pkt   <= w_pkt_next;
      r_busy      <= '0;
      r_seq       <= r_seq + SEQ_W'(1);
    end else begin
      if (rec_ready) r_rec_valid <= 1'b0;
      r_busy <= r_busy | w_stall;
    end
  end

  assign rec_valid = r_rec_valid;
  assign rec_pkt   = r_rec_pkt;

endmodule
